// File: rtl/sha3_round_scheduler_if.sv
// Handshake bundle for the SHA-3 round scheduler:
// new-state entry (in_*) and completed-state exit (out_*).
interface sha3_round_scheduler_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_tag
  );

  modport slave (
    input  in_valid,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_tag
  );
endinterface

// File: rtl/sha3_round_scheduler.sv
// Control sequencer for a recirculating Keccak-f round loop.
// Tracks {valid,count,tag} per loop slot; drives datapath mux/round/bypass.
module sha3_round_scheduler #(
  parameter  int LATENCY = 4,
  parameter  int ROUNDS  = 24,
  parameter  int TAG_W   = 4,
  localparam int OCC_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  sha3_round_scheduler_if.slave bus,
  output logic             issue_sel,
  output logic             issue_valid,
  output logic [4:0]       issue_round,
  output logic             issue_bypass,
  output logic [OCC_W-1:0] occupancy
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("sha3_round_scheduler: LATENCY must be >= 1");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("sha3_round_scheduler: ROUNDS must be 1..31");
  end

  typedef struct packed {
    logic             vld;
    logic [4:0]       cnt;
    logic [TAG_W-1:0] tag;
  } rec_t;

  rec_t             ring_q [LATENCY];
  rec_t             ring_d [LATENCY];
  rec_t             head;
  rec_t             entry;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  logic       head_done;
  logic       xfer;
  logic       free;
  logic       park;
  logic       recirc;
  logic       accept;
  logic       sel_c;
  logic       ival_c;
  logic [4:0] round_c;
  logic       byp_c;

  assign head = ring_q[LATENCY-1];

  // free, park and recirc are mutually exclusive and cover every head state
  always_comb begin
    head_done = head.vld && (head.cnt == 5'(ROUNDS));
    xfer      = head_done && bus.out_ready;
    free      = !head.vld || xfer;
    park      = head_done && !bus.out_ready;
    recirc    = head.vld && !head_done;
    accept    = free && bus.in_valid;

    entry   = '0;
    sel_c   = 1'b0;
    ival_c  = 1'b0;
    round_c = 5'd0;
    byp_c   = 1'b0;

    unique case (1'b1)
      free: begin
        if (bus.in_valid) begin
          entry.vld = 1'b1;
          entry.cnt = 5'd1;
          entry.tag = bus.in_tag;
          sel_c     = 1'b1;
          ival_c    = 1'b1;
        end
      end
      park: begin
        entry.vld = 1'b1;
        entry.cnt = 5'(ROUNDS);
        entry.tag = head.tag;
        ival_c    = 1'b1;
        byp_c     = 1'b1;
      end
      recirc: begin
        entry.vld = 1'b1;
        entry.cnt = head.cnt + 5'd1;
        entry.tag = head.tag;
        ival_c    = 1'b1;
        round_c   = head.cnt;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    ring_d[0] = entry;
    for (int i = 1; i < LATENCY; i++) begin
      ring_d[i] = ring_q[i-1];
    end
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(xfer);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        ring_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      ring_q <= ring_d;
      occ_q  <= occ_d;
    end
  end

  // Gate with rstn: a cleared ring would otherwise advertise in_ready in reset
  assign bus.in_ready  = rstn && free;
  assign bus.out_valid = rstn && head_done;
  assign bus.out_tag   = (rstn && head_done) ? head.tag : '0;
  assign issue_sel     = rstn && sel_c;
  assign issue_valid   = rstn && ival_c;
  assign issue_round   = rstn ? round_c : 5'd0;
  assign issue_bypass  = rstn && byp_c;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_sha3_round_scheduler.sv
// Directed bench: L=4/R=24 instance for single, backpressure, full pipe
// and reset flush; L=1/R=3 instance for the minimal loop.
module tb_sha3_round_scheduler;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sha3_round_scheduler_if #(.TAG_W(4)) ifa ();
  sha3_round_scheduler_if #(.TAG_W(4)) ifb ();

  logic       a_sel, a_ival, a_byp;
  logic [4:0] a_round;
  logic [2:0] a_occ;
  logic       b_sel, b_ival, b_byp;
  logic [4:0] b_round;
  logic [0:0] b_occ;

  sha3_round_scheduler #(
    .LATENCY(4), .ROUNDS(24), .TAG_W(4)
  ) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa),
    .issue_sel(a_sel), .issue_valid(a_ival),
    .issue_round(a_round), .issue_bypass(a_byp),
    .occupancy(a_occ)
  );

  sha3_round_scheduler #(
    .LATENCY(1), .ROUNDS(3), .TAG_W(4)
  ) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb),
    .issue_sel(b_sel), .issue_valid(b_ival),
    .issue_round(b_round), .issue_bypass(b_byp),
    .occupancy(b_occ)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             name, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_a_zero(input string name);
    chk({name, ".in_ready"}, 32'(ifa.in_ready), 0);
    chk({name, ".out_valid"}, 32'(ifa.out_valid), 0);
    chk({name, ".out_tag"}, 32'(ifa.out_tag), 0);
    chk({name, ".sel"}, 32'(a_sel), 0);
    chk({name, ".ival"}, 32'(a_ival), 0);
    chk({name, ".round"}, 32'(a_round), 0);
    chk({name, ".byp"}, 32'(a_byp), 0);
    chk({name, ".occ"}, 32'(a_occ), 0);
  endtask

  initial begin
    int  nt;
    logic iss, rec, done, acc;

    rstn = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_tag = 4'd0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b1; ifb.in_tag = 4'd0; ifb.out_ready = 1'b1;
    #2;
    chk_a_zero("rst0");
    chk("rst0.b_in_ready", 32'(ifb.in_ready), 0);
    chk("rst0.b_occ", 32'(b_occ), 0);
    tick();
    tick();
    rstn = 1'b1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;

    // LATENCY=1, ROUNDS=3
    tick();
    ifb.in_valid = 1'b1; ifb.in_tag = 4'd7; ifb.out_ready = 1'b1;
    #1;
    chk("l1.c0.in_ready", 32'(ifb.in_ready), 1);
    chk("l1.c0.sel", 32'(b_sel), 1);
    chk("l1.c0.ival", 32'(b_ival), 1);
    chk("l1.c0.round", 32'(b_round), 0);
    tick();
    ifb.in_valid = 1'b0;
    #1;
    chk("l1.c1.in_ready", 32'(ifb.in_ready), 0);
    chk("l1.c1.round", 32'(b_round), 1);
    chk("l1.c1.sel", 32'(b_sel), 0);
    chk("l1.c1.occ", 32'(b_occ), 1);
    tick();
    #1;
    chk("l1.c2.in_ready", 32'(ifb.in_ready), 0);
    chk("l1.c2.round", 32'(b_round), 2);
    chk("l1.c2.out_valid", 32'(ifb.out_valid), 0);
    tick();
    #1;
    chk("l1.c3.out_valid", 32'(ifb.out_valid), 1);
    chk("l1.c3.out_tag", 32'(ifb.out_tag), 7);
    chk("l1.c3.in_ready", 32'(ifb.in_ready), 1);
    chk("l1.c3.ival", 32'(b_ival), 0);
    tick();
    #1;
    chk("l1.c4.out_valid", 32'(ifb.out_valid), 0);
    chk("l1.c4.occ", 32'(b_occ), 0);

    // Single hash, tag 3 at cycle 10
    ifa.out_ready = 1'b1;
    for (int c = 0; c <= 110; c++) begin
      tick();
      ifa.in_valid = (c == 10);
      ifa.in_tag = 4'd3;
      #1;
      iss = (c >= 10) && (c <= 102) && ((c - 10) % 4 == 0);
      chk("single.ival", 32'(a_ival), 32'(iss));
      chk("single.round", 32'(a_round), iss ? 32'((c - 10) / 4) : 0);
      chk("single.sel", 32'(a_sel), 32'(c == 10));
      chk("single.byp", 32'(a_byp), 0);
      chk("single.in_ready", 32'(ifa.in_ready), 32'(!(iss && c != 10)));
      chk("single.out_valid", 32'(ifa.out_valid), 32'(c == 106));
      chk("single.out_tag", 32'(ifa.out_tag), (c == 106) ? 3 : 0);
      chk("single.occ", 32'(a_occ), 32'((c >= 11) && (c <= 106)));
    end

    // Backpressure: consumer stalls until cycle 114
    for (int c = 0; c <= 116; c++) begin
      tick();
      ifa.in_valid = (c == 10);
      ifa.in_tag = 4'd5;
      ifa.out_ready = (c >= 114);
      #1;
      rec  = (c >= 10) && (c <= 102) && ((c - 10) % 4 == 0);
      done = (c == 106) || (c == 110) || (c == 114);
      iss  = (c >= 10) && (c <= 110) && ((c - 10) % 4 == 0);
      chk("bp.ival", 32'(a_ival), 32'(iss));
      chk("bp.byp", 32'(a_byp), 32'((c == 106) || (c == 110)));
      chk("bp.round", 32'(a_round), rec ? 32'((c - 10) / 4) : 0);
      chk("bp.out_valid", 32'(ifa.out_valid), 32'(done));
      chk("bp.out_tag", 32'(ifa.out_tag), done ? 5 : 0);
      chk("bp.in_ready", 32'(ifa.in_ready), 32'(!(iss && c != 10)));
      chk("bp.occ", 32'(a_occ), 32'((c >= 11) && (c <= 114)));
    end

    // Full pipe: tags 0..5 with in_valid held high
    ifa.out_ready = 1'b1;
    nt = 0;
    for (int c = 0; c <= 145; c++) begin
      tick();
      ifa.in_valid = (nt < 6);
      ifa.in_tag = 4'(nt);
      #1;
      acc = (c <= 3) || (c == 96) || (c == 97);
      if (c <= 99) begin
        chk("full.in_ready", 32'(ifa.in_ready),
            32'((c <= 3) || (c >= 96)));
        chk("full.out_valid", 32'(ifa.out_valid), 32'(c >= 96));
        chk("full.out_tag", 32'(ifa.out_tag),
            (c >= 96) ? 32'(c - 96) : 0);
        chk("full.occ", 32'(a_occ),
            (c <= 3) ? 32'(c) : (c == 99) ? 3 : 4);
        chk("full.sel", 32'(a_sel), 32'(acc));
      end
      if (acc) nt++;
    end

    // Reset with tags 4 and 5 still in flight
    tick();
    rstn = 1'b0;
    ifa.in_valid = 1'b1;
    #1;
    chk_a_zero("rst_mid0");
    tick();
    #1;
    chk_a_zero("rst_mid1");
    tick();
    rstn = 1'b1;
    ifa.in_valid = 1'b0;

    // Fresh hash after release; flushed tags must never emerge
    for (int c = 0; c <= 110; c++) begin
      tick();
      ifa.in_valid = (c == 2);
      ifa.in_tag = 4'd9;
      #1;
      chk("post.out_valid", 32'(ifa.out_valid), 32'(c == 98));
      chk("post.out_tag", 32'(ifa.out_tag), (c == 98) ? 9 : 0);
      chk("post.occ", 32'(a_occ), 32'((c >= 3) && (c <= 98)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
